// File: rtl/bounce_pulse_gen_if.sv
// bounce_pulse_gen_if: request/status bundle between a pulse-train requester and the generator
interface bounce_pulse_gen_if;
    logic       start;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       out;
    logic [3:0] pulses_sent;
    modport master (output start, count, input busy, done, out, pulses_sent);
    modport slave  (input start, count, output busy, done, out, pulses_sent);
endinterface

// File: rtl/bounce_pulse_gen.sv
// bounce_pulse_gen: emits a programmed number of pulses, each settled edge preceded by a bounce burst
module bounce_pulse_gen #(
    parameter int HIGH_CYC     = 8,
    parameter int LOW_CYC      = 8,
    parameter int BOUNCE_EDGES = 4,
    parameter int BOUNCE_CYC   = 1
) (
    input logic               clk,
    input logic               rst_n,
    bounce_pulse_gen_if.slave bus
);
    localparam int MAXHL = HIGH_CYC > LOW_CYC ? HIGH_CYC : LOW_CYC;
    localparam int MAXC  = MAXHL > BOUNCE_CYC ? MAXHL : BOUNCE_CYC;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int PW    = $clog2(BOUNCE_EDGES + 2);

    typedef enum logic [2:0] {IDLE, BOUNCE_R, HIGH, BOUNCE_F, LOW, DONE} state_t;

    // With bounce disabled the settled levels follow each other directly.
    localparam state_t RISE = BOUNCE_EDGES == 0 ? HIGH : BOUNCE_R;
    localparam state_t FALL = BOUNCE_EDGES == 0 ? LOW : BOUNCE_F;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [3:0]    count_q, count_d, pulses_q, pulses_d;
    logic          out_q, out_d, busy_q, busy_d, done_q, done_d;

    // Next state and counters; outputs are decoded from the next state so they land registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        ph_d     = ph_q;
        count_d  = count_q;
        pulses_d = pulses_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                ph_d  = '0;
                if (bus.start) begin
                    pulses_d = '0;
                    count_d  = bus.count;
                    state_d  = bus.count != '0 ? RISE : DONE;
                end
            end
            BOUNCE_R, BOUNCE_F: begin
                if (cnt_q == CW'(BOUNCE_CYC - 1)) begin
                    cnt_d = '0;
                    ph_d  = ph_q + 1'b1;
                    if (ph_q == PW'(BOUNCE_EDGES - 1)) begin
                        ph_d    = '0;
                        state_d = state_q == BOUNCE_R ? HIGH : LOW;
                    end
                end
            end
            HIGH: begin
                if (cnt_q == CW'(HIGH_CYC - 1)) begin
                    cnt_d    = '0;
                    pulses_d = pulses_q + 1'b1;
                    state_d  = FALL;
                end
            end
            LOW: begin
                if (cnt_q == CW'(LOW_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = pulses_q == count_q ? DONE : RISE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        out_d  = (state_d == HIGH) || (state_d == BOUNCE_R && !ph_d[0]) || (state_d == BOUNCE_F && ph_d[0]);
        busy_d = state_d inside {BOUNCE_R, HIGH, BOUNCE_F, LOW};
        done_d = state_d == DONE;
    end

    // State, counters and registered outputs; reset aborts any request without a done strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ph_q     <= '0;
            count_q  <= '0;
            pulses_q <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            count_q  <= count_d;
            pulses_q <= pulses_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pulses_sent = pulses_q;
endmodule

// File: tb/tb_bounce_pulse_gen.sv
// tb_bounce_pulse_gen: drives two generator configurations and compares against a waveform model
module tb_bounce_pulse_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   sel = 0;
    int   n_chk = 0;
    int   n_err = 0;

    bounce_pulse_gen_if ifa ();
    bounce_pulse_gen_if ifb ();

    bounce_pulse_gen dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    bounce_pulse_gen #(.HIGH_CYC(2), .LOW_CYC(3), .BOUNCE_EDGES(0), .BOUNCE_CYC(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    logic       o_out, o_busy, o_done;
    logic [3:0] o_ps;
    assign o_out  = sel != 0 ? ifb.out : ifa.out;
    assign o_busy = sel != 0 ? ifb.busy : ifa.busy;
    assign o_done = sel != 0 ? ifb.done : ifa.done;
    assign o_ps   = sel != 0 ? ifb.pulses_sent : ifa.pulses_sent;

    int hc, lc, be, bc;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int period();
        return 2 * be * bc + hc + lc;
    endfunction

    // Expected line level in cycle k (1-based) of a train, from the pulse shape rules.
    function automatic bit model(input int k);
        int pos, b;
        b   = be * bc;
        pos = (k - 1) % period();
        if (pos < b) return ((pos / bc) % 2) == 0;
        pos -= b;
        if (pos < hc) return 1'b1;
        pos -= hc;
        if (pos < b) return ((pos / bc) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic set_start(input bit v, input logic [3:0] c);
        ifa.count = c;
        ifb.count = c;
        ifa.start = v && sel == 0;
        ifb.start = v && sel != 0;
    endtask

    task automatic run_req(input int n, input int extra, input bit inject, input int abort_k);
        int np, eo, eb, dnum, dcyc;
        bit e;
        np = n * period();
        eo = 0; eb = 0; dnum = 0; dcyc = -1;
        @(negedge clk);
        set_start(1'b1, 4'(n));
        @(posedge clk);
        #1 set_start(1'b0, 4'($urandom));
        for (int k = 1; k <= np + 1 + extra; k++) begin
            @(negedge clk);
            if (inject && k == 3) set_start(1'b1, 4'd9);
            else set_start(1'b0, 4'($urandom));
            e = k <= np ? model(k) : 1'b0;
            eo += int'(o_out !== e);
            eb += int'(o_busy !== (k <= np));
            if (o_done === 1'b1) begin
                dnum++;
                dcyc = k;
            end
            if (k == abort_k) begin
                chk("pre_abort_out", eo, 0);
                chk("pre_abort_busy", eb, 0);
                chk("pre_abort_level", int'(o_out), 1);
                rst_n = 1'b0;
                #1;
                chk("abort_out", int'(o_out), 0);
                chk("abort_busy", int'(o_busy), 0);
                chk("abort_pulses", int'(o_ps), 0);
                repeat (2) @(negedge clk) dnum += int'(o_done !== 1'b0);
                rst_n = 1'b1;
                repeat (3) @(negedge clk) dnum += int'(o_done !== 1'b0 || o_busy !== 1'b0);
                chk("abort_no_done", dnum, 0);
                return;
            end
        end
        chk("out_wave", eo, 0);
        chk("busy_wave", eb, 0);
        chk("done_count", dnum, 1);
        chk("done_cycle", dcyc, np + 1);
        chk("pulses_sent", int'(o_ps), n);
    endtask

    task automatic use_cfg(input int s);
        sel = s;
        hc = s != 0 ? 2 : 8;
        lc = s != 0 ? 3 : 8;
        be = s != 0 ? 0 : 4;
        bc = 1;
    endtask

    initial begin
        use_cfg(0);
        set_start(1'b0, 4'd0);
        repeat (3) @(negedge clk);
        chk("rst_out", int'(o_out), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_pulses", int'(o_ps), 0);
        rst_n = 1'b1;
        run_req(3, 2, 1'b0, 0);
        run_req(0, 3, 1'b0, 0);
        run_req(2, 4, 1'b0, 0);
        run_req(2, 4, 1'b1, 0);
        run_req(5, 0, 1'b0, 24 + 4 + 3);
        run_req(1, 2, 1'b0, 0);
        run_req(2, 0, 1'b0, 0);
        run_req(1, 2, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            run_req(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0, 0);
        end
        use_cfg(1);
        run_req(15, 2, 1'b0, 0);
        run_req(0, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            run_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0, 0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
